bounce_gen: RTL
===============

Name: bounce_gen

Overview:
- Switch-bounce emulator: the driving end of the debounced-switch interface.
- Takes a clean requested level and drives a contact-bounce waveform on sw_o. sw_o feeds the sw_i input of the debouncer, in the bench or on FPGA for demos.
- Bounce edges are paced by the same ClkRate/Baud tick scheme as the debouncer. Each burst ends with a settle interval and a done pulse.

Parameters:
- ClkRate, 10_000_000, clock frequency in Hz.
- Baud, 1_000_000, bounce edge rate in Hz. Div = ClkRate/Baud; Div >= 2 is enforced by an elaboration check.
- PairBits, 3, width of the random bounce-pair field. Pairs per burst are 1..2^PairBits.
- RandEn, 1, 1 = random pair count from the LFSR; 0 = use FixedPairs.
- FixedPairs, 3, pairs per burst when RandEn = 0. Legal range 1..2^PairBits.
- SettleTicks, 4, ticks sw_o is held stable after the last toggle before done. Must be >= 1.
- LfsrSeed, 16'hACE1, LFSR reset value. Must be nonzero.

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, reset; asynchronous, active-low.
- level_i, in, 1, requested clean switch level.
- sw_o, out, 1, bouncing switch output.
- busy_o, out, 1, burst or settle in progress.
- done_o, out, 1, one-cycle pulse when sw_o has settled at the new level.

Behaviour:
- Reset (rst_i low, asynchronous): sw_o=0, busy_o=0, done_o=0, stable level=0, state IDLE, tick counter=0, LFSR=LfsrSeed. All outputs are registered.
- Tick counter: free-running 0..Div-1, runs in all states. tick=1 in the cycle counter==Div-1, giving one tick every Div cycles.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advances every clock.
- IDLE:
  - sw_o = stable level, busy_o = 0.
  - In the cycle that level_i != stable level: capture target=level_i and load pairs (RandEn ? LFSR[PairBits-1:0]+1 : FixedPairs).
  - Also load toggles = 2*pairs and go to BOUNCE.
  - Effect is visible next cycle (t+1): sw_o=target, busy_o=1.
- BOUNCE:
  - On each tick: sw_o toggles and toggles decrements.
  - When the decrement reaches 0, sw_o is back at target (even toggle count); load settle=SettleTicks and go to SETTLE.
  - The first toggle is on the first tick strictly after entry. No phase realignment of the tick counter.
- SETTLE:
  - sw_o holds target. On each tick settle decrements.
  - On reaching 0: done_o=1 for exactly one cycle, stable level=target, busy_o=0, go to IDLE. All of this is visible in the same next cycle.
- level_i changes while busy_o=1 are ignored; the captured target is never altered.
- Back-to-back requests: the first IDLE cycle after done compares level_i with the updated stable level. If they differ, a new burst starts in that cycle, with done_o and the new busy_o rise adjacent.
- A glitch on level_i lasting one cycle while IDLE still starts a full burst; the comparison is level-based, with no filtering.
- Reset mid-burst: immediate return to reset values. No done_o is emitted.
- Burst duration from level change to done is between (2*pairs+SettleTicks-1)*Div+1 and (2*pairs+SettleTicks)*Div cycles, depending on tick phase.

Test Plan:
- Reset: hold rst_i low 3 cycles with level_i=1 -> sw_o=0, busy_o=0, done_o=0 throughout, and asynchronously on assertion.
- Fixed burst (RandEn=0, FixedPairs=3, Div=10, SettleTicks=4): level_i 0->1 -> the following must all hold:
  - sw_o=1 at t+1.
  - Exactly 6 toggles, 10 cycles apart, ending at 1.
  - Then 4 ticks stable.
  - Single done_o pulse; busy_o high from t+1 until the done_o cycle.
- Falling burst: same configuration after settle, level_i 1->0 -> mirror waveform, 6 toggles, final sw_o=0, one done_o.
- Ignored change: toggle level_i 1->0->1 during BOUNCE -> no change to toggle count or target. After done, level_i==stable, so no new burst and busy_o stays 0.
- Mid-burst reset: assert rst_i after 3rd toggle -> sw_o=0, busy_o=0, no done_o. After release with level_i=1, a fresh 6-toggle burst runs.
- Random mode with debouncer in loop (RandEn=1, 20 level changes): every burst has an even toggle count of 2..16. Debouncer db_level_o equals level_i after each done_o, with one db_tick_o per 0->1 change.

Source files
------------

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level request into a paced contact-bounce
// burst on sw_o, followed by a settle interval and a one-cycle done pulse.
module bounce_gen #(
  parameter int          ClkRate     = 10_000_000,
  parameter int          Baud        = 1_000_000,
  parameter int          PairBits    = 3,
  parameter int          RandEn      = 1,
  parameter int          FixedPairs  = 3,
  parameter int          SettleTicks = 4,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic sw_o,
  output logic busy_o,
  output logic done_o
);

  localparam int Div  = ClkRate / Baud;
  localparam int CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam int PW   = PairBits + 1;
  localparam int TogW = PairBits + 2;
  localparam int SetW = (SettleTicks > 1) ? $clog2(SettleTicks + 1) : 1;

  if (Div < 2) begin : g_div_chk
    $error("bounce_gen: ClkRate/Baud must be at least 2");
  end
  if (SettleTicks < 1) begin : g_settle_chk
    $error("bounce_gen: SettleTicks must be at least 1");
  end
  if (RandEn == 0 && (FixedPairs < 1 || FixedPairs > (1 << PairBits))) begin : g_pairs_chk
    $error("bounce_gen: FixedPairs out of range");
  end
  if (LfsrSeed == 16'h0000) begin : g_seed_chk
    $error("bounce_gen: LfsrSeed must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              tick;
  logic [15:0]       lfsr_q;
  logic [PW-1:0]     pairs;
  logic              sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stable_q, stable_d;
  logic              target_q, target_d;
  logic [TogW-1:0]   tog_q, tog_d;
  logic [SetW-1:0]   settle_q, settle_d;

  // Free-running tick divider; never realigned to a request.
  assign tick = (cnt_q == CntW'(Div - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      lfsr_q <= LfsrSeed;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    if (RandEn != 0) pairs = {1'b0, lfsr_q[PairBits-1:0]} + 1'b1;
    else             pairs = PW'(FixedPairs);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
      target_q <= 1'b0;
      tog_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sw_q     <= sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stable_q <= stable_d;
      target_q <= target_d;
      tog_q    <= tog_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    stable_d = stable_q;
    target_d = target_q;
    tog_d    = tog_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        sw_d   = stable_q;
        busy_d = 1'b0;
        if (level_i != stable_q) begin
          target_d = level_i;
          tog_d    = {pairs, 1'b0};
          sw_d     = level_i;
          busy_d   = 1'b1;
          state_d  = BOUNCE;
        end
      end
      BOUNCE: begin
        // An even number of toggles always lands back on the target level.
        if (tick) begin
          sw_d  = ~sw_q;
          tog_d = tog_q - 1'b1;
          if (tog_q == TogW'(1)) begin
            settle_d = SetW'(SettleTicks);
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        sw_d = target_q;
        if (tick) begin
          settle_d = settle_q - 1'b1;
          if (settle_q == SetW'(1)) begin
            done_d   = 1'b1;
            stable_d = target_q;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw_o   = sw_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
